// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage: single-cycle ALU plus 32-cycle shift-add
//               unsigned multiplier with EX/MEM backpressure and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    input  logic [3:0]  aluop,
    input  logic        is_mult,
    input  logic [1:0]  alusrc,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    input  logic [31:0] sign_ext32,
    input  logic [4:0]  dest_in,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        zero,
    output logic        ovf,
    output logic [4:0]  dest_out
);

    localparam logic [3:0] c_ALU_SLL  = 4'd0;
    localparam logic [3:0] c_ALU_SRL  = 4'd1;
    localparam logic [3:0] c_ALU_ADD  = 4'd2;
    localparam logic [3:0] c_ALU_SUB  = 4'd3;
    localparam logic [3:0] c_ALU_AND  = 4'd4;
    localparam logic [3:0] c_ALU_OR   = 4'd5;
    localparam logic [3:0] c_ALU_XOR  = 4'd6;
    localparam logic [3:0] c_ALU_NOR  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;
    localparam logic [5:0] c_LAST_BIT = 6'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_mdest;

    logic [31:0] w_opb;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu;
    logic        w_ovf;
    logic        w_hold;
    logic        w_accept;
    logic        w_mult_done;
    logic [63:0] w_partial;
    logic [63:0] w_acc_next;

    always_comb begin
        w_opb = 32'd0;
        case (alusrc)
            2'd0:    w_opb = rdat2;
            2'd1:    w_opb = sign_ext32;
            2'd2:    w_opb = {27'd0, sign_ext32[10:6]};
            default: w_opb = 32'd0;
        endcase
    end

    assign w_sum  = rdat1 + w_opb;
    assign w_diff = rdat1 - w_opb;

    always_comb begin
        w_alu = 32'd0;
        w_ovf = 1'b0;
        case (aluop)
            c_ALU_SLL:  w_alu = rdat1 << w_opb[4:0];
            c_ALU_SRL:  w_alu = rdat1 >> w_opb[4:0];
            c_ALU_ADD: begin
                w_alu = w_sum;
                w_ovf = (rdat1[31] == w_opb[31]) && (w_sum[31] != rdat1[31]);
            end
            c_ALU_SUB: begin
                w_alu = w_diff;
                w_ovf = (rdat1[31] != w_opb[31]) && (w_diff[31] != rdat1[31]);
            end
            c_ALU_AND:  w_alu = rdat1 & w_opb;
            c_ALU_OR:   w_alu = rdat1 | w_opb;
            c_ALU_XOR:  w_alu = rdat1 ^ w_opb;
            c_ALU_NOR:  w_alu = ~(rdat1 | w_opb);
            c_ALU_SLT:  w_alu = {31'd0, ($signed(rdat1) < $signed(w_opb))};
            c_ALU_SLTU: w_alu = {31'd0, (rdat1 < w_opb)};
            default:    w_alu = 32'd0;
        endcase
    end

    // A result the consumer has not taken yet blocks every register update.
    assign w_hold      = out_valid && mem_stall;
    assign w_accept    = (r_state == ST_IDLE) && in_valid && !flush && !w_hold;
    assign w_mult_done = (r_state == ST_MULT) && (r_count == c_LAST_BIT);
    assign w_partial   = r_mplier[r_count[4:0]] ? ({32'd0, r_mcand} << r_count[4:0]) : 64'd0;
    assign w_acc_next  = r_acc + w_partial;

    assign stall = (r_state == ST_MULT)
                || ((r_state == ST_IDLE) && in_valid && is_mult && !flush)
                || w_hold;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ST_IDLE;
            r_count   <= 6'd0;
            r_acc     <= 64'd0;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_mdest   <= 5'd0;
            out_valid <= 1'b0;
            result_lo <= 32'd0;
            result_hi <= 32'd0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            dest_out  <= 5'd0;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            r_count   <= 6'd0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_mult) begin
                            r_state   <= ST_MULT;
                            r_mcand   <= rdat1;
                            r_mplier  <= w_opb;
                            r_mdest   <= dest_in;
                            r_acc     <= 64'd0;
                            r_count   <= 6'd0;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            result_lo <= w_alu;
                            result_hi <= 32'd0;
                            zero      <= (w_alu == 32'd0);
                            ovf       <= w_ovf;
                            dest_out  <= dest_in;
                        end
                    end else if (!w_hold) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (w_mult_done) begin
                        // The final bit waits at count 31 until the old result drains.
                        if (!w_hold) begin
                            r_state   <= ST_IDLE;
                            r_count   <= 6'd0;
                            r_acc     <= w_acc_next;
                            out_valid <= 1'b1;
                            result_lo <= w_acc_next[31:0];
                            result_hi <= w_acc_next[63:32];
                            zero      <= (w_acc_next == 64'd0);
                            ovf       <= 1'b0;
                            dest_out  <= r_mdest;
                        end
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 6'd1;
                        if (!w_hold) begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [3:0]  aluop;
    logic        is_mult;
    logic [1:0]  alusrc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] sign_ext32;
    logic [4:0]  dest_in;
    logic        flush;
    logic        mem_stall;
    logic        stall;
    logic        out_valid;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        zero;
    logic        ovf;
    logic [4:0]  dest_out;

    ex_stage dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .aluop      (aluop),
        .is_mult    (is_mult),
        .alusrc     (alusrc),
        .rdat1      (rdat1),
        .rdat2      (rdat2),
        .sign_ext32 (sign_ext32),
        .dest_in    (dest_in),
        .flush      (flush),
        .mem_stall  (mem_stall),
        .stall      (stall),
        .out_valid  (out_valid),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .zero       (zero),
        .ovf        (ovf),
        .dest_out   (dest_out)
    );

    always #5 CLK = ~CLK;

    localparam logic [3:0] c_SLL = 4'd0, c_SRL = 4'd1, c_ADD = 4'd2, c_SUB = 4'd3;
    localparam logic [3:0] c_AND = 4'd4, c_OR = 4'd5, c_XOR = 4'd6, c_NOR = 4'd7;
    localparam logic [3:0] c_SLT = 4'd8, c_SLTU = 4'd9;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic [4:0]  dest;
    } res_t;

    res_t sb[$];
    res_t r_last;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [3:0] op, input logic mult, input logic [1:0] src,
                                   input logic [31:0] a, input logic [31:0] r2,
                                   input logic [31:0] se, input logic [4:0] dest);
        res_t              r;
        logic [31:0]       b;
        logic [63:0]       p;
        logic signed [63:0] s;
        b = (src == 2'd0) ? r2 : (src == 2'd1) ? se : (src == 2'd2) ? (se >> 6) & 32'h1F : 32'd0;
        r = '0;
        r.dest = dest;
        if (mult) begin
            p    = {32'd0, a} * {32'd0, b};
            r.lo = p[31:0];
            r.hi = p[63:32];
            r.zero = (p == 64'd0);
        end else begin
            case (op)
                c_SLL:  r.lo = a << b[4:0];
                c_SRL:  r.lo = a >> b[4:0];
                c_ADD, c_SUB: begin
                    s = (op == c_ADD) ? ($signed({{32{a[31]}}, a}) + $signed({{32{b[31]}}, b}))
                                      : ($signed({{32{a[31]}}, a}) - $signed({{32{b[31]}}, b}));
                    r.lo  = s[31:0];
                    r.ovf = (s != $signed({{32{s[31]}}, s[31:0]}));
                end
                c_AND:  r.lo = a & b;
                c_OR:   r.lo = a | b;
                c_XOR:  r.lo = a ^ b;
                c_NOR:  r.lo = ~(a | b);
                c_SLT:  r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                c_SLTU: r.lo = (a < b) ? 32'd1 : 32'd0;
                default: r.lo = 32'd0;
            endcase
            r.zero = (r.lo == 32'd0);
        end
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_t cur, input res_t exp);
        chk({tag, ".lo"},   {32'd0, cur.lo},   {32'd0, exp.lo});
        chk({tag, ".hi"},   {32'd0, cur.hi},   {32'd0, exp.hi});
        chk({tag, ".zero"}, {63'd0, cur.zero}, {63'd0, exp.zero});
        chk({tag, ".ovf"},  {63'd0, cur.ovf},  {63'd0, exp.ovf});
        chk({tag, ".dest"}, {59'd0, cur.dest}, {59'd0, exp.dest});
    endtask

    // One clock; a fresh result is popped from the queue, a stalled one must not move.
    task automatic tick();
        logic ov_b;
        logic ms_b;
        res_t cur;
        ov_b = out_valid;
        ms_b = mem_stall;
        @(posedge CLK);
        #1;
        cur = '{result_lo, result_hi, zero, ovf, dest_out};
        if (out_valid) begin
            if (ov_b && ms_b) begin
                cmp_res("held", cur, r_last);
            end else if (sb.size() == 0) begin
                chk("spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                cmp_res("result", cur, sb.pop_front());
            end
            r_last = cur;
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic mult, input logic [1:0] src,
                          input logic [31:0] a, input logic [31:0] r2,
                          input logic [31:0] se, input logic [4:0] dest);
        in_valid = 1'b1; aluop = op; is_mult = mult; alusrc = src;
        rdat1 = a; rdat2 = r2; sign_ext32 = se; dest_in = dest;
    endtask

    task automatic push_cur();
        sb.push_back(model(aluop, is_mult, alusrc, rdat1, rdat2, sign_ext32, dest_in));
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] src, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] se, input logic [4:0] dest);
        set_op(op, 1'b0, src, a, r2, se, dest);
        push_cur();
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        is_mult  = 1'b0;
    endtask

    task automatic wait_result(input int bound, output int n);
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    int n_cyc;

    initial begin
        nRST = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        idle(); aluop = 4'd0; alusrc = 2'd0;
        rdat1 = 32'd0; rdat2 = 32'd0; sign_ext32 = 32'd0; dest_in = 5'd0;
        #12;
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.result_lo", {32'd0, result_lo}, 64'd0);
        chk("rst.result_hi", {32'd0, result_hi}, 64'd0);
        chk("rst.zero_ovf",  {62'd0, zero, ovf}, 64'd0);
        chk("rst.dest_out",  {59'd0, dest_out},  64'd0);
        chk("rst.stall",     {63'd0, stall},     64'd0);
        set_op(c_ADD, 1'b1, 2'd0, 32'd1, 32'd1, 32'd0, 5'd1);
        #1;
        chk("rst.stall_mult", {63'd0, stall}, 64'd1);
        idle();
        @(negedge CLK);
        nRST = 1'b1;

        // Signed overflow on ADD, then back-to-back single-cycle ops
        issue(c_ADD, 2'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd3);
        chk("add.result_lo", {32'd0, result_lo}, 64'h8000_0000);
        chk("add.ovf_zero",  {62'd0, ovf, zero}, 64'd2);
        chk("add.out_valid", {63'd0, out_valid}, 64'd1);
        issue(c_SLT, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd4);
        chk("slt.result_lo", {32'd0, result_lo}, 64'd1);
        issue(c_SLTU, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd5);
        chk("sltu.result_lo", {32'd0, result_lo}, 64'd0);
        issue(c_SUB, 2'd0, 32'd5, 32'd5, 32'd0, 5'd6);
        chk("sub.zero", {63'd0, zero}, 64'd1);
        issue(c_SUB, 2'd0, 32'h8000_0000, 32'd1, 32'd0, 5'd7);
        issue(c_SLL, 2'd2, 32'd1, 32'd0, 32'h0000_0100, 5'd8);
        chk("sll.result_lo", {32'd0, result_lo}, 64'd16);
        issue(c_SRL, 2'd0, 32'h8000_0000, 32'hFFFF_FFE4, 32'd0, 5'd9);
        issue(c_AND, 2'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 5'd10);
        issue(c_OR,  2'd1, 32'h0000_1200, 32'd0, 32'h8000_0034, 5'd11);
        issue(c_XOR, 2'd0, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'd0, 5'd12);
        issue(c_NOR, 2'd0, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 5'd13);
        issue(c_ADD, 2'd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14);
        chk("src3.result_lo", {32'd0, result_lo}, 64'd7);
        idle();
        tick();
        chk("valid_clears", {63'd0, out_valid}, 64'd0);

        // Full-width multiply: 32 cycles of stall, then the product
        set_op(c_ADD, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd15);
        #1;
        chk("mult.stall_req", {63'd0, stall}, 64'd1);
        push_cur();
        tick();
        idle();
        for (int i = 0; i < 31; i++) begin
            tick();
            chk($sformatf("mult.stall_c%0d", i), {62'd0, stall, out_valid}, 64'd2);
        end
        tick();
        chk("mult.done", {62'd0, out_valid, stall}, 64'd2);
        chk("mult.result_hi", {32'd0, result_hi}, 64'hFFFF_FFFE);
        chk("mult.result_lo", {32'd0, result_lo}, 64'h0000_0001);
        tick();

        set_op(c_ADD, 1'b1, 2'd1, 32'h0000_1003, 32'd0, 32'h0001_2345, 5'd16);
        push_cur();
        tick();
        idle();
        wait_result(40, n_cyc);
        chk("mult2.latency", 64'(n_cyc), 64'd32);
        set_op(c_ADD, 1'b1, 2'd0, 32'd0, 32'h1234_5678, 32'd0, 5'd17);
        push_cur();
        tick();
        idle();
        wait_result(40, n_cyc);
        chk("mult0.zero", {63'd0, zero}, 64'd1);
        tick();

        // Flush aborts a multiply in flight
        set_op(c_ADD, 1'b1, 2'd0, 32'd3, 32'd5, 32'd0, 5'd18);
        tick();
        idle();
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush.valid_stall", {62'd0, out_valid, stall}, 64'd0);
        repeat (40) tick();
        chk("flush.no_result", {63'd0, out_valid}, 64'd0);

        // Backpressure: result held, waiting ADD enters after release
        issue(c_ADD, 2'd0, 32'd1, 32'd2, 32'd0, 5'd19);
        mem_stall = 1'b1;
        set_op(c_ADD, 1'b0, 2'd0, 32'd10, 32'd20, 32'd0, 5'd20);
        #1;
        chk("hold.stall", {63'd0, stall}, 64'd1);
        repeat (3) begin
            tick();
            chk("hold.state", {62'd0, stall, out_valid}, 64'd3);
            chk("hold.result_lo", {32'd0, result_lo}, 64'd3);
        end
        mem_stall = 1'b0;
        push_cur();
        tick();
        idle();
        chk("hold.next_lo", {32'd0, result_lo}, 64'd30);

        // Multiply must not start while the previous result is stuck
        mem_stall = 1'b1;
        set_op(c_ADD, 1'b1, 2'd0, 32'd6, 32'd7, 32'd0, 5'd21);
        repeat (2) tick();
        mem_stall = 1'b0;
        push_cur();
        tick();
        idle();
        chk("mwait.valid_drop", {63'd0, out_valid}, 64'd0);
        wait_result(40, n_cyc);
        chk("mwait.latency", 64'(n_cyc), 64'd32);

        // Asynchronous reset in the middle of a multiply
        tick();
        set_op(c_ADD, 1'b1, 2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 5'd22);
        tick();
        idle();
        repeat (5) tick();
        #2;
        nRST = 1'b0;
        #1;
        chk("arst.valid_stall", {62'd0, out_valid, stall}, 64'd0);
        chk("arst.result_lo",   {32'd0, result_lo},   64'd0);
        chk("arst.result_hi",   {32'd0, result_hi},   64'd0);
        chk("arst.dest_flags",  {57'd0, dest_out, zero, ovf}, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (40) tick();
        chk("arst.no_result", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
